// File: rtl/mult_div.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply and
// restoring shift-subtract divide, one bit per cycle, sign fix-up in a final cycle.
module mult_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept, req_signed, req_div, sign_diff, op_div;
  op_e              req_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_neg;

  always_comb begin
    req_op     = op_e'(funct[1:0]);
    accept     = start && (alu_op == 2'b10) && (funct[5:2] == 4'b0110) && (state_q == IDLE);
    req_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
    req_div    = funct[1];
    a_mag      = (req_signed && a[WIDTH-1]) ? -a : a;
    b_mag      = (req_signed && b[WIDTH-1]) ? -b : b;
    op_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    sign_diff  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    // acc_q is the product high half for multiply and the partial remainder for divide
    mul_sum    = {1'b0, acc_q} + {1'b0, opd_q};
    div_shift  = {acc_q, quo_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opd_q};
    prod_mag   = {acc_q, quo_q};
    prod_neg   = -prod_mag;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = req_op;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          quo_d   = req_div ? a_mag : b_mag;
          opd_d   = req_div ? b_mag : a_mag;
        end
      end
      CALC: begin
        if (op_div) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else if (quo_q[0]) begin
          {acc_d, quo_d} = {mul_sum, quo_q[WIDTH-1:1]};
        end else begin
          {acc_d, quo_d} = {1'b0, acc_q, quo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MULTU: {hi_d, lo_d} = prod_mag;
          OP_MULT:  {hi_d, lo_d} = sign_diff ? prod_neg : prod_mag;
          OP_DIVU: begin
            lo_d = quo_q;
            hi_d = acc_q;
          end
          default: begin
            lo_d = sign_diff ? -quo_q : quo_q;
            hi_d = a_q[WIDTH-1] ? -acc_q : acc_q;
          end
        endcase
        if (op_div && (b_q == '0)) begin
          hi_d = a_q;
          lo_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; latency is expressed in terms of WIDTH.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request; sampled at rising edge while idle.
REQ-005 Port: alu_op  input  2  main-control ALU opcode; only 2'b10 (R-type) requests are honoured.
REQ-006 Port: funct  input  6  R-type function field: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
REQ-007 Port: a  input  WIDTH  rs operand (multiplicand / dividend).
REQ-008 Port: b  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 Port: hi  output  WIDTH  HI register: product upper half / remainder.
REQ-010 Port: lo  output  WIDTH  LO register: product lower half / quotient.
REQ-011 Port: busy  output  1  operation in progress.
REQ-012 Port: done  output  1  one-cycle pulse; hi/lo hold the new result.

Function
REQ-013 The block SHALL accept a request at edge N only if start=1, alu_op=2'b10, funct is one of the four codes in REQ-006, and the state is IDLE.
- Any other combination is ignored: no state change, busy stays 0.
REQ-014 On accept, the block SHALL latch a, b and the operation.
- Input changes while busy have no effect.
REQ-015 The state machine SHALL have the states IDLE, CALC and FIX.
- IDLE -> CALC on accept.
- CALC runs exactly WIDTH cycles, driven by a count from 0 to WIDTH-1.
- CALC -> FIX after the last iteration.
- FIX -> IDLE after one cycle.
REQ-016 busy SHALL be 1 from edge N+1 through the cycle ending at edge N+WIDTH+2, and 0 otherwise.
REQ-017 hi and lo SHALL update only at the FIX->IDLE edge (N+WIDTH+2).
- done SHALL be 1 for exactly the following cycle.
- hi and lo hold their value at all other times.
REQ-018 A start asserted during busy or in the done cycle SHALL be treated as follows:
- During busy: ignored.
- In the done cycle: accepted, since the state is IDLE; done and the new busy are then high together.
REQ-019 MULTU SHALL produce {hi,lo} = unsigned a * unsigned b (full 2*WIDTH product) using a shift-add iteration.
REQ-020 MULT SHALL produce the two's-complement 2*WIDTH product.
- The magnitude product is computed in CALC.
- It is negated in FIX when sign(a) XOR sign(b) = 1.
REQ-021 DIVU SHALL produce lo = a / b and hi = a % b (unsigned) using a restoring shift-subtract iteration, one quotient bit per cycle.
REQ-022 DIV SHALL divide magnitudes in CALC.
- The quotient is negated in FIX when the operand signs differ.
- The remainder takes the sign of the dividend (truncating division).
REQ-023 Divide by zero (b=0, DIV or DIVU) SHALL give hi = a and lo = all ones, with normal latency.
REQ-024 Signed overflow SHALL be handled as follows:
- DIV with a = most-negative and b = -1 gives lo = most-negative, hi = 0, with normal latency.
REQ-025 Arithmetic SHALL be modulo 2^(2*WIDTH) for products and WIDTH bits for quotient/remainder, with no overflow flag.

Reset
REQ-026 While rst=1, independent of clk, the block SHALL set the following:
- state = IDLE.
- The iteration count is 0.
- busy = 0, done = 0, hi = 0, lo = 0.
- Latched operands are 0.
REQ-027 Reset mid-operation SHALL abort the operation with no hi/lo update and no done pulse.
- The first request after rst deasserts is accepted normally.

Verification
REQ-028 MULTU a=FFFFFFFF b=FFFFFFFF -> busy for 33 cycles, then hi=FFFFFFFE, lo=00000001, done high for 1 cycle.
REQ-029 MULT a=FFFFFFFD (-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB (-21).
REQ-030 Division checks:
- DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
REQ-031 Boundary division checks:
- DIVU a=12345678 b=0 -> hi=12345678, lo=FFFFFFFF.
- DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-032 Ignore and reset checks:
- Start MULTU 2*3, then pulse start with DIVU at cycle 5 -> ignored; result hi=0, lo=6.
- Repeat, asserting rst at cycle 10 -> busy=0, hi=lo=0, no done; next request completes correctly.
REQ-033 Non-qualifying request checks:
- start=1, alu_op=00, funct=011000 -> busy stays 0, hi/lo unchanged.
- start=1, alu_op=10, funct=100000 -> busy stays 0, hi/lo unchanged.
